spi_slave: RTL and testbench
============================

// Module: spi_slave
// PURPOSE
//  SPI target (slave) end of the team's SPI link: it talks to spi_master over one chip select (cs_n).
//  It runs entirely in the clk domain and oversamples sclk, cs_n and mosi. It uses SPI mode 0, MSB first.
//  It deserialises mosi into rx_data and serialises a preloaded tx byte onto miso.
//  Its parallel side has valid/ready handshakes, so it can be driven from a register file or a FIFO.
// PARAMETERS
//  DATA_W       8  bits per SPI word (frame byte)
//  SYNC_STAGES  2  synchroniser flops on sclk/cs_n/mosi (min 2)
// PORTS
//  clk       in   1       system clock; all logic is on its rising edge
//  reset     in   1       synchronous, active-high reset
//  sclk      in   1       SPI clock from the master, asynchronous to clk
//  cs_n      in   1       chip select, active low, asynchronous
//  mosi      in   1       master-out serial data
//  miso      out  1       slave-out serial data
//  tx_data   in   DATA_W  next word to transmit
//  tx_valid  in   1       tx_data is valid
//  tx_ready  out  1       tx holding register is empty
//  rx_data   out  DATA_W  last fully received word
//  rx_valid  out  1       rx_data holds an unread word
//  rx_ready  in   1       consumer accepts rx_data
//  busy      out  1       a frame is in progress (synchronised cs_n is low)
//  overrun   out  1       1-clk pulse: a completed word overwrote an unread word
// BEHAVIOUR
//  Reset (clk reset, synchronous, active-high):
//   miso=0, tx_ready=1, rx_data=0, rx_valid=0, busy=0, overrun=0.
//   Counters and shift registers clear to 0. Synchronised cs_n presets to 1 and synchronised sclk to 0.
//   A reset mid-frame aborts the frame. The slave ignores the rest of that frame until cs_n rises and falls again.
//  Sync and edges: each input passes through SYNC_STAGES flops.
//   sclk_rise = s_sclk & ~s_sclk_d; sclk_fall is the mirror.
//   Edges are ignored while s_cs_n=1.
//   Timing requirement: the sclk half-period must be >= SYNC_STAGES+2 clk (spi_master uses 10).
//  FSM IDLE -> ACTIVE on the s_cs_n falling edge; ACTIVE -> IDLE on s_cs_n high (any bit count).
//   busy=1 exactly while in ACTIVE.
//  Frame start (IDLE -> ACTIVE cycle):
//   bit_cnt <= 0.
//   tx_sh <= hold if tx holding register is full, else all-zero (underrun, no flag).
//   The holding register is freed, so tx_ready returns to 1 on the next cycle.
//   miso = tx_sh[DATA_W-1] from the next cycle.
//  sclk_rise (ACTIVE): rx_sh <= {rx_sh[DATA_W-2:0], s_mosi}; bit_cnt increments.
//   When bit_cnt reaches DATA_W on this edge:
//    rx_data <= the new word; rx_valid <= 1; bit_cnt wraps to 0.
//    If rx_valid was 1 and rx_ready was 0 in that same cycle, overrun pulses for 1 clk (the new word wins).
//  sclk_fall (ACTIVE):
//   If bit_cnt==0 (word boundary, continuous frame), tx_sh reloads from hold or zero, as at frame start.
//   Otherwise tx_sh shifts left by 1.
//   miso always presents tx_sh MSB.
//  cs_n rise mid-word: the partial rx word is discarded (no rx_valid) and the in-flight tx word is lost.
//   bit_cnt <= 0 and miso <= 0.
//  tx handshake: the holding register loads on tx_valid & tx_ready. tx_ready = ~full.
//   A same-cycle load and consume is allowed: consume first, then load; full stays 1.
//  rx handshake: rx_valid clears on rx_valid & rx_ready unless a new word completes in the same cycle.
//   In that case rx_valid stays 1, with the new data and no overrun.
//  Latency: rx_valid rises SYNC_STAGES+1 clk after the raw 8th sclk rising edge.
// CONFIGURATION
//  SPI_SLAVE_MISO_OE_EN defined:
//   Adds the port miso_oe out 1 (1 while ACTIVE, reset 0) for a shared, tri-stated MISO line.
//   miso holds its last value when idle.
//  Not defined: no miso_oe port; miso is forced to 0 whenever not ACTIVE.
// TESTING
//  1. Load tx 0xA5, master sends 0x3C on cs0 -> rx_data=0x3C, rx_valid=1, miso bits 1,0,1,0,0,1,0,1, tx_ready=1 after start.
//  2. Nothing loaded, master sends 0xFF -> miso=0 for all 8 bits, rx_data=0xFF, overrun=0.
//  3. cs_n high after 5 sclk rises -> no rx_valid, busy=0; next frame 0x81 -> rx_data=0x81.
//  4. One cs-low frame carrying 0x11,0x22 with tx 0xC3 then 0x5A, rx_ready=0 -> two completions, overrun pulse at the 2nd, rx_data=0x22, miso=0xC3 then 0x5A.
//  5. reset asserted mid-word -> all outputs at reset values; the remainder of the frame yields no rx_valid.
//  6. With SPI_SLAVE_MISO_OE_EN: miso_oe=1 exactly while busy=1; without it, miso=0 whenever cs_n=1.

Source files
------------

// File: rtl/spi_slave.sv
// SPI mode-0 target, MSB first, fully oversampled in the clk domain.
// Optional feature: define SPI_SLAVE_MISO_OE_EN to add miso_oe_o for a shared MISO line.
module spi_slave #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sclk_i,
    input  logic              cs_n_i,
    input  logic              mosi_i,
    output logic              miso_o,
`ifdef SPI_SLAVE_MISO_OE_EN
    output logic              miso_oe_o,
`endif
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              rx_valid_o,
    input  logic              rx_ready_i,
    output logic              busy_o,
    output logic              overrun_o
);

    localparam int unsigned CntW = $clog2(DATA_W + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(DATA_W);

    typedef enum logic {StIdle, StActive} state_e;

    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q, flush_q;
    logic                   sclk_prev_q, cs_prev_q, armed_q;
    logic                   s_sclk, s_cs_n, s_mosi;

    assign s_sclk = sclk_sync_q[SYNC_STAGES-1];
    assign s_cs_n = cs_sync_q[SYNC_STAGES-1];
    assign s_mosi = mosi_sync_q[SYNC_STAGES-1];

    // armed_q blocks a frame start until cs_n has been seen high with real (non-preset)
    // synchroniser contents, so a reset in mid-frame drops the rest of that frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            flush_q     <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
            armed_q     <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n_i};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
            flush_q     <= {flush_q[SYNC_STAGES-2:0], 1'b1};
            sclk_prev_q <= s_sclk;
            cs_prev_q   <= s_cs_n;
            if (&flush_q && s_cs_n) armed_q <= 1'b1;
        end
    end

    state_e            state_q;
    logic [CntW-1:0]   bit_cnt_q;
    logic [DATA_W-1:0] rx_sh_q, tx_sh_q, hold_q, rx_data_q;
    logic              full_q, rx_valid_q, overrun_q, miso_q;

    logic              sclk_rise, sclk_fall, start, active_run, cs_rise, reload;
    logic              word_done, tx_load;
    logic [CntW-1:0]   cnt_inc;
    logic [DATA_W-1:0] rx_word, tx_sh_d;

    always_comb begin
        sclk_rise  = s_sclk & ~sclk_prev_q & ~s_cs_n;
        sclk_fall  = ~s_sclk & sclk_prev_q & ~s_cs_n;
        start      = (state_q == StIdle) & armed_q & ~s_cs_n & cs_prev_q;
        active_run = (state_q == StActive) & ~s_cs_n;
        cs_rise    = (state_q == StActive) & s_cs_n;
        reload     = start | (active_run & sclk_fall & (bit_cnt_q == '0));
        cnt_inc    = bit_cnt_q + 1'b1;
        word_done  = active_run & sclk_rise & (cnt_inc == CntMax);
        rx_word    = {rx_sh_q[DATA_W-2:0], s_mosi};
        tx_load    = tx_valid_i & ~full_q;
        tx_sh_d    = tx_sh_q;
        if (reload) begin
            tx_sh_d = full_q ? hold_q : '0;
        end else if (active_run && sclk_fall) begin
            tx_sh_d = {tx_sh_q[DATA_W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            bit_cnt_q  <= '0;
            rx_sh_q    <= '0;
            tx_sh_q    <= '0;
            hold_q     <= '0;
            full_q     <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
            miso_q     <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            tx_sh_q   <= tx_sh_d;
            // Consume before load: a same-cycle load keeps the holding register full.
            full_q    <= (full_q & ~reload) | tx_load;
            if (tx_load) hold_q <= tx_data_i;

            if (word_done) begin
                rx_data_q  <= rx_word;
                rx_valid_q <= 1'b1;
                overrun_q  <= rx_valid_q & ~rx_ready_i;
            end else if (rx_ready_i) begin
                rx_valid_q <= 1'b0;
            end

            if (start || active_run) begin
                miso_q <= tx_sh_d[DATA_W-1];
            end

            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q   <= StActive;
                        bit_cnt_q <= '0;
                    end
                end
                StActive: begin
                    if (cs_rise) begin
                        state_q   <= StIdle;
                        bit_cnt_q <= '0;
                        rx_sh_q   <= '0;
`ifndef SPI_SLAVE_MISO_OE_EN
                        miso_q    <= 1'b0;
`endif
                    end else if (sclk_rise) begin
                        rx_sh_q   <= rx_word;
                        bit_cnt_q <= word_done ? '0 : cnt_inc;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy_o     = (state_q == StActive);
    assign miso_o     = miso_q;
    assign tx_ready_o = ~full_q;
    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;
    assign overrun_o  = overrun_q;
`ifdef SPI_SLAVE_MISO_OE_EN
    assign miso_oe_o  = busy_o;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: vector table, hand-written corner sequences and
// random multi-word frames compared against a word-level reference model.
module tb_spi_slave;

    localparam int HALF = 10;

    typedef logic [7:0] word_arr_t [4];
    typedef logic       flag_arr_t [4];

    typedef struct {
        logic       load;
        logic [7:0] tx;
        logic [7:0] mosi;
        logic [7:0] exp_miso;
        logic [7:0] exp_rx;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
    logic       miso;
    logic [7:0] tx_data = '0;
    logic       tx_valid = 1'b0, tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid, rx_ready = 1'b0;
    logic       busy, overrun;
`ifdef SPI_SLAVE_MISO_OE_EN
    logic       miso_oe;
`endif

    int n_checks = 0;
    int n_pass = 0;
    int n_overrun = 0;
    int n_idle_bad = 0;
    int clks_since_rise = 0;
    int last_lat = -1;
    logic rx_valid_prev = 1'b0;
    logic [7:0] rx_q[$];

    spi_slave #(.DATA_W(8), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .sclk_i     (sclk),
        .cs_n_i     (cs_n),
        .mosi_i     (mosi),
        .miso_o     (miso),
`ifdef SPI_SLAVE_MISO_OE_EN
        .miso_oe_o  (miso_oe),
`endif
        .tx_data_i  (tx_data),
        .tx_valid_i (tx_valid),
        .tx_ready_o (tx_ready),
        .rx_data_o  (rx_data),
        .rx_valid_o (rx_valid),
        .rx_ready_i (rx_ready),
        .busy_o     (busy),
        .overrun_o  (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) clks_since_rise++;
    always @(posedge sclk) clks_since_rise = 0;

    // Records every completed word: a fresh rx_valid, or a replacement flagged by overrun.
    always @(negedge clk) begin
        if (rx_valid && !rx_valid_prev) begin
            rx_q.push_back(rx_data);
            last_lat = clks_since_rise;
        end else if (overrun) begin
            rx_q.push_back(rx_data);
        end
        if (overrun) n_overrun++;
`ifdef SPI_SLAVE_MISO_OE_EN
        if (miso_oe !== busy) n_idle_bad++;
`else
        if (!busy && miso !== 1'b0) n_idle_bad++;
`endif
        rx_valid_prev = rx_valid;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_tx(input logic [7:0] d);
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic clear_rx();
        @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        wait_clk(1);
        rx_q.delete();
    endtask

    task automatic shift_bit(input logic b, output logic got);
        mosi = b;
        wait_clk(HALF);
        sclk = 1'b1;
        got = miso;
        wait_clk(HALF);
        sclk = 1'b0;
    endtask

    task automatic run_frame(input int nw, input word_arr_t mw, input word_arr_t tw,
                             input flag_arr_t tl, output word_arr_t got);
        logic g;
        got = '{default: '0};
        if (tl[0]) load_tx(tw[0]);
        @(negedge clk);
        cs_n = 1'b0;
        wait_clk(HALF);
        for (int w = 0; w < nw; w++) begin
            for (int b = 0; b < 8; b++) begin
                if (b == 2 && w + 1 < nw && tl[w+1]) load_tx(tw[w+1]);
                shift_bit(mw[w][7-b], g);
                got[w][7-b] = g;
            end
        end
        wait_clk(HALF);
        cs_n = 1'b1;
        wait_clk(2 * HALF);
    endtask

    vec_t      vecs[4];
    word_arr_t mw, tw, got;
    flag_arr_t tl;
    int        ovr0;
    logic      g;

    initial begin
        vecs[0] = '{1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C};
        vecs[1] = '{1'b0, 8'h00, 8'hFF, 8'h00, 8'hFF};
        vecs[2] = '{1'b1, 8'h81, 8'h00, 8'h81, 8'h00};
        vecs[3] = '{1'b1, 8'hFF, 8'h5A, 8'hFF, 8'h5A};

        wait_clk(3);
        check("reset miso", 32'(miso), 32'h0);
        check("reset tx_ready", 32'(tx_ready), 32'h1);
        check("reset rx_data", 32'(rx_data), 32'h0);
        check("reset rx_valid", 32'(rx_valid), 32'h0);
        check("reset busy", 32'(busy), 32'h0);
        check("reset overrun", 32'(overrun), 32'h0);
        reset = 1'b0;
        wait_clk(5);

        // Single-word vectors, consumer holding off.
        for (int i = 0; i < 4; i++) begin
            clear_rx();
            ovr0 = n_overrun;
            mw = '{vecs[i].mosi, 8'h00, 8'h00, 8'h00};
            tw = '{vecs[i].tx, 8'h00, 8'h00, 8'h00};
            tl = '{1'b0, 1'b0, 1'b0, 1'b0};
            if (vecs[i].load) begin
                load_tx(vecs[i].tx);
                check($sformatf("vec%0d tx_ready after load", i), 32'(tx_ready), 32'h0);
            end
            run_frame(1, mw, tw, tl, got);
            check($sformatf("vec%0d miso", i), 32'(got[0]), 32'(vecs[i].exp_miso));
            check($sformatf("vec%0d rx_data", i), 32'(rx_data), 32'(vecs[i].exp_rx));
            check($sformatf("vec%0d rx_valid", i), 32'(rx_valid), 32'h1);
            check($sformatf("vec%0d overrun", i), 32'(n_overrun - ovr0), 32'h0);
            check($sformatf("vec%0d tx_ready", i), 32'(tx_ready), 32'h1);
            check($sformatf("vec%0d busy", i), 32'(busy), 32'h0);
            if (i == 0) check("rx latency clks", 32'(last_lat), 32'd3);
        end

        // Abort after 5 bits, then a clean frame.
        clear_rx();
        @(negedge clk);
        cs_n = 1'b0;
        wait_clk(HALF);
        for (int b = 0; b < 5; b++) shift_bit(1'b1, g);
        wait_clk(HALF);
        cs_n = 1'b1;
        wait_clk(2 * HALF);
        check("abort rx_valid", 32'(rx_valid), 32'h0);
        check("abort words", 32'(rx_q.size()), 32'h0);
        check("abort busy", 32'(busy), 32'h0);
        mw = '{8'h81, 8'h00, 8'h00, 8'h00};
        tl = '{1'b0, 1'b0, 1'b0, 1'b0};
        run_frame(1, mw, tw, tl, got);
        check("after abort rx_data", 32'(rx_data), 32'h81);
        check("after abort rx_valid", 32'(rx_valid), 32'h1);

        // Reset mid-word with a held tx word and an unread rx word.
        @(negedge clk);
        cs_n = 1'b0;
        wait_clk(HALF);
        shift_bit(1'b0, g);
        load_tx(8'h99);
        for (int b = 0; b < 2; b++) shift_bit(1'b1, g);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset miso", 32'(miso), 32'h0);
        check("midreset tx_ready", 32'(tx_ready), 32'h1);
        check("midreset rx_data", 32'(rx_data), 32'h0);
        check("midreset rx_valid", 32'(rx_valid), 32'h0);
        check("midreset busy", 32'(busy), 32'h0);
        check("midreset overrun", 32'(overrun), 32'h0);
        rx_q.delete();
        for (int b = 0; b < 5; b++) shift_bit(1'b1, g);
        check("midreset busy later", 32'(busy), 32'h0);
        wait_clk(HALF);
        cs_n = 1'b1;
        wait_clk(2 * HALF);
        check("midreset no word", 32'(rx_q.size()), 32'h0);
        check("midreset rx_valid end", 32'(rx_valid), 32'h0);
        mw = '{8'h5A, 8'h00, 8'h00, 8'h00};
        run_frame(1, mw, tw, tl, got);
        check("recover rx_data", 32'(rx_data), 32'h5A);

        // Two words in one frame with the consumer stalled.
        clear_rx();
        ovr0 = n_overrun;
        mw = '{8'h11, 8'h22, 8'h00, 8'h00};
        tw = '{8'hC3, 8'h5A, 8'h00, 8'h00};
        tl = '{1'b1, 1'b1, 1'b0, 1'b0};
        run_frame(2, mw, tw, tl, got);
        check("two-word miso0", 32'(got[0]), 32'hC3);
        check("two-word miso1", 32'(got[1]), 32'h5A);
        check("two-word completions", 32'(rx_q.size()), 32'h2);
        if (rx_q.size() == 2) begin
            check("two-word first", 32'(rx_q[0]), 32'h11);
            check("two-word second", 32'(rx_q[1]), 32'h22);
        end
        check("two-word overruns", 32'(n_overrun - ovr0), 32'h1);
        check("two-word rx_data", 32'(rx_data), 32'h22);

        // Random frames against the word-level model, consumer always ready.
        clear_rx();
        rx_ready = 1'b1;
        ovr0 = n_overrun;
        for (int f = 0; f < 20; f++) begin
            int nw;
            nw = int'($urandom_range(1, 3));
            for (int w = 0; w < 4; w++) begin
                mw[w] = 8'($urandom);
                tw[w] = 8'($urandom);
                tl[w] = 1'($urandom_range(0, 1));
            end
            rx_q.delete();
            run_frame(nw, mw, tw, tl, got);
            for (int w = 0; w < nw; w++) begin
                check($sformatf("rnd%0d.%0d miso", f, w), 32'(got[w]),
                      32'(tl[w] ? tw[w] : 8'h00));
                if (rx_q.size() > 0) begin
                    check($sformatf("rnd%0d.%0d rx", f, w), 32'(rx_q.pop_front()),
                          32'(mw[w]));
                end else begin
                    check($sformatf("rnd%0d.%0d rx missing", f, w), 32'h1, 32'h0);
                end
            end
            check($sformatf("rnd%0d extra words", f), 32'(rx_q.size()), 32'h0);
            check($sformatf("rnd%0d tx_ready", f), 32'(tx_ready), 32'h1);
        end
        check("rnd overruns", 32'(n_overrun - ovr0), 32'h0);
        rx_ready = 1'b0;

`ifdef SPI_SLAVE_MISO_OE_EN
        check("miso_oe tracks busy", 32'(n_idle_bad), 32'h0);
`else
        check("miso low when idle", 32'(n_idle_bad), 32'h0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
